// File: rtl/adam_axil_slv_regs.sv
// AXI-Lite register bank: NO_REGS word registers with byte strobes, SLVERR on
// out-of-range addresses, and parallel register/write-pulse outputs for hardware.
module adam_axil_slv_regs #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NO_REGS = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDR_WIDTH-1:0]         aw_addr,
    input  logic [2:0]                    aw_prot,
    input  logic                          aw_valid,
    output logic                          aw_ready,
    input  logic [DATA_WIDTH-1:0]         w_data,
    input  logic [STRB_WIDTH-1:0]         w_strb,
    input  logic                          w_valid,
    output logic                          w_ready,
    output logic [1:0]                    b_resp,
    output logic                          b_valid,
    input  logic                          b_ready,
    input  logic [ADDR_WIDTH-1:0]         ar_addr,
    input  logic [2:0]                    ar_prot,
    input  logic                          ar_valid,
    output logic                          ar_ready,
    output logic [DATA_WIDTH-1:0]         r_data,
    output logic [1:0]                    r_resp,
    output logic                          r_valid,
    input  logic                          r_ready,
    output logic [NO_REGS*DATA_WIDTH-1:0] regs_q,
    output logic [NO_REGS-1:0]            wr_pulse
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [NO_REGS-1:0][DATA_WIDTH-1:0] regs;
    logic                  aw_held, w_held;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_WIDTH-1:0] w_strb_q;

    logic                  aw_hs, w_hs, ar_hs, commit;
    logic [ADDR_WIDTH-1:0] wr_addr, wr_idx, rd_idx;
    logic [DATA_WIDTH-1:0] wr_data, rd_word;
    logic [STRB_WIDTH-1:0] wr_strb;
    logic [NO_REGS-1:0]    wr_sel, rd_sel;
    logic                  unused;

    assign unused   = ^{aw_prot, ar_prot};
    assign regs_q   = regs;

    assign aw_ready = !aw_held && !b_valid;
    assign w_ready  = !w_held && !b_valid;
    assign ar_ready = !r_valid;

    assign aw_hs    = aw_valid && aw_ready;
    assign w_hs     = w_valid && w_ready;
    assign ar_hs    = ar_valid && ar_ready;

    // A held beat and a live handshake are interchangeable for committing.
    assign wr_addr  = aw_held ? aw_addr_q : aw_addr;
    assign wr_data  = w_held ? w_data_q : w_data;
    assign wr_strb  = w_held ? w_strb_q : w_strb;
    assign commit   = (aw_held || aw_hs) && (w_held || w_hs);

    // Full-width index compare, so any set upper address bit lands out of range.
    assign wr_idx   = wr_addr >> 2;
    assign rd_idx   = ar_addr >> 2;

    always_comb begin
        wr_sel  = '0;
        rd_sel  = '0;
        rd_word = '0;
        for (int i = 0; i < NO_REGS; i++) begin
            if (wr_idx == ADDR_WIDTH'(i)) wr_sel[i] = 1'b1;
            if (rd_idx == ADDR_WIDTH'(i)) begin
                rd_sel[i] = 1'b1;
                rd_word   = regs[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            regs      <= {NO_REGS{RESET_VALUE}};
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            b_valid   <= 1'b0;
            b_resp    <= '0;
            r_valid   <= 1'b0;
            r_resp    <= '0;
            r_data    <= '0;
            wr_pulse  <= '0;
        end else begin
            wr_pulse <= '0;

            if (commit) begin
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
                b_valid  <= 1'b1;
                b_resp   <= (|wr_sel) ? RESP_OKAY : RESP_SLVERR;
                wr_pulse <= wr_sel;
                for (int i = 0; i < NO_REGS; i++)
                    for (int k = 0; k < STRB_WIDTH; k++)
                        if (wr_sel[i] && wr_strb[k])
                            regs[i][k*8 +: 8] <= wr_data[k*8 +: 8];
            end else begin
                if (aw_hs) begin
                    aw_held   <= 1'b1;
                    aw_addr_q <= aw_addr;
                end
                if (w_hs) begin
                    w_held   <= 1'b1;
                    w_data_q <= w_data;
                    w_strb_q <= w_strb;
                end
            end

            if (b_valid && b_ready) b_valid <= 1'b0;

            // Read samples pre-edge register state, so a same-edge write returns old data.
            if (ar_hs) begin
                r_valid <= 1'b1;
                r_data  <= rd_word;
                r_resp  <= (|rd_sel) ? RESP_OKAY : RESP_SLVERR;
            end else if (r_valid && r_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adam_axil_slv_regs.sv
// Scoreboard bench for adam_axil_slv_regs: expected B/R responses are queued at
// issue time and compared by a negedge monitor when the handshake occurs.
module tb_adam_axil_slv_regs;

    localparam int AW = 32, DW = 32, NR = 8, SW = DW / 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [AW-1:0]   aw_addr = '0, ar_addr = '0;
    logic [2:0]      aw_prot = '0, ar_prot = '0;
    logic            aw_valid = 1'b0, w_valid = 1'b0, ar_valid = 1'b0;
    logic            b_ready = 1'b1, r_ready = 1'b1;
    logic [DW-1:0]   w_data = '0;
    logic [SW-1:0]   w_strb = '0;
    logic            aw_ready, w_ready, b_valid, ar_ready, r_valid;
    logic [1:0]      b_resp, r_resp;
    logic [DW-1:0]   r_data;
    logic [NR*DW-1:0] regs_q;
    logic [NR-1:0]   wr_pulse;

    adam_axil_slv_regs #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NO_REGS(NR), .RESET_VALUE('0)) dut (
        .clk(clk), .rst(rst),
        .aw_addr(aw_addr), .aw_prot(aw_prot), .aw_valid(aw_valid), .aw_ready(aw_ready),
        .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
        .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
        .ar_addr(ar_addr), .ar_prot(ar_prot), .ar_valid(ar_valid), .ar_ready(ar_ready),
        .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready),
        .regs_q(regs_q), .wr_pulse(wr_pulse)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    logic [DW-1:0] mdl [NR];
    logic [1:0]    bq[$];
    logic [DW+1:0] rq[$];

    task automatic chk(input string tag, input logic [NR*DW-1:0] got, input logic [NR*DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NR*DW-1:0] mdl_flat();
        logic [NR*DW-1:0] f;
        for (int i = 0; i < NR; i++) f[i*DW +: DW] = mdl[i];
        return f;
    endfunction

    function automatic bit in_rng(input logic [AW-1:0] a);
        return (a >> 2) < NR;
    endfunction

    // Monitor: a handshake visible at negedge completes at the following posedge.
    always @(negedge clk) begin
        if (rst) begin
            if (b_valid && b_ready) begin
                if (bq.size() == 0) chk("b_unexpected", 1, 0);
                else chk("b_resp", b_resp, bq.pop_front());
            end
            if (r_valid && r_ready) begin
                if (rq.size() == 0) chk("r_unexpected", 1, 0);
                else chk("r_data_resp", {r_data, r_resp}, rq.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        logic ar_, wr_;
        logic [NR-1:0] pulse;
        pulse = '0;
        bq.push_back(in_rng(a) ? 2'b00 : 2'b10);
        if (in_rng(a)) begin
            pulse[a >> 2] = 1'b1;
            for (int k = 0; k < SW; k++) if (s[k]) mdl[a >> 2][k*8 +: 8] = d[k*8 +: 8];
        end
        aw_addr = a; w_data = d; w_strb = s; aw_valid = 1'b1; w_valid = 1'b1;
        for (int t = 0; t < 50 && (aw_valid || w_valid); t++) begin
            @(negedge clk); ar_ = aw_ready; wr_ = w_ready;
            tick();
            if (ar_) aw_valid = 1'b0;
            if (wr_) w_valid = 1'b0;
        end
        if (aw_valid || w_valid) begin
            chk("wr_timeout", 1, 0);
            aw_valid = 1'b0; w_valid = 1'b0;
        end
        chk("wr_bvalid", b_valid, 1);
        chk("wr_pulse", wr_pulse, pulse);
        chk("wr_regs_q", regs_q, mdl_flat());
    endtask

    task automatic rd(input logic [AW-1:0] a);
        logic rdy;
        rq.push_back(in_rng(a) ? {mdl[a >> 2], 2'b00} : {{DW{1'b0}}, 2'b10});
        ar_addr = a; ar_valid = 1'b1;
        for (int t = 0; t < 50 && ar_valid; t++) begin
            @(negedge clk); rdy = ar_ready;
            tick();
            if (rdy) ar_valid = 1'b0;
        end
        if (ar_valid) begin
            chk("rd_timeout", 1, 0);
            ar_valid = 1'b0;
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 50 && (bq.size() != 0 || rq.size() != 0); t++) tick();
        if (bq.size() != 0 || rq.size() != 0) begin
            chk("drain_timeout", 1, 0);
            bq.delete(); rq.delete();
        end
    endtask

    initial begin
        for (int i = 0; i < NR; i++) mdl[i] = '0;
        tick(); tick();
        rst = 1'b1;
        chk("rst_bvalid", b_valid, 0);
        chk("rst_rvalid", r_valid, 0);
        chk("rst_regs", regs_q, mdl_flat());
        chk("rst_pulse", wr_pulse, 0);
        chk("rst_awready", aw_ready, 1);

        // 1: same-cycle AW/W, single-cycle pulse, read back
        wr(32'h0C, 32'hDEADBEEF, 4'hF);
        tick();
        chk("t1_pulse_once", wr_pulse, 0);
        rd(32'h0C);
        drain();

        // 2: partial strobe
        wr(32'h0C, 32'h11223344, 4'h5);
        rd(32'h0C);
        drain();

        // 3: W three cycles ahead of AW
        w_data = 32'h5; w_strb = 4'hF; w_valid = 1'b1;
        tick(); w_valid = 1'b0;
        chk("t3_wready_low", w_ready, 0);
        tick(); tick();
        chk("t3_no_commit", b_valid, 0);
        mdl[1] = 32'h5; bq.push_back(2'b00);
        aw_addr = 32'h04; aw_valid = 1'b1;
        tick(); aw_valid = 1'b0;
        chk("t3_bvalid", b_valid, 1);
        chk("t3_pulse", wr_pulse, 8'b0000_0010);
        chk("t3_regs_q", regs_q, mdl_flat());
        drain();

        // 4: out of range write and read
        wr(32'h20, 32'hCAFEF00D, 4'hF);
        rd(32'h1000);
        drain();

        // 5: backpressure on B and R
        b_ready = 1'b0; r_ready = 1'b0;
        wr(32'h08, 32'h7, 4'hF);
        rd(32'h08);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t5_stall", {b_valid, r_valid, b_resp, r_resp, r_data, aw_ready, w_ready, ar_ready},
                {1'b1, 1'b1, 2'b00, 2'b00, mdl[2], 1'b0, 1'b0, 1'b0});
        end
        tick();
        b_ready = 1'b1; r_ready = 1'b1;
        @(negedge clk);
        chk("t5_aw_blocked", aw_ready, 0);
        tick();
        @(negedge clk);
        chk("t5_aw_free", aw_ready, 1);
        tick();
        drain();

        // 6: same-edge read and write of reg2 returns old value
        bq.push_back(2'b00);
        rq.push_back({mdl[2], 2'b00});
        mdl[2] = 32'h9;
        aw_addr = 32'h08; ar_addr = 32'h08; w_data = 32'h9; w_strb = 4'hF;
        aw_valid = 1'b1; w_valid = 1'b1; ar_valid = 1'b1;
        @(negedge clk);
        chk("t6_ready", {aw_ready, w_ready, ar_ready}, 3'b111);
        tick();
        aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
        drain();
        rd(32'h08);
        drain();

        // reset while a B response is pending
        b_ready = 1'b0;
        wr(32'h00, 32'h1234, 4'hF);
        rst = 1'b0;
        tick();
        bq.delete();
        for (int i = 0; i < NR; i++) mdl[i] = '0;
        chk("t6_rst_bvalid", b_valid, 0);
        chk("t6_rst_regs", regs_q, mdl_flat());
        chk("t6_rst_pulse", wr_pulse, 0);
        rst = 1'b1; b_ready = 1'b1;
        tick(); tick();
        chk("t6_idle_b", b_valid, 0);
        chk("sb_empty", bq.size() + rq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
